// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared constants and state encoding for the packet-buffer controller
package ram_ctrl_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 4;
  localparam int RAM_DEPTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD,
    ST_PRIME,
    ST_DRAIN
  } ctrl_state_e;

endpackage

// File: rtl/ram_burst_buffer.sv
// rtl/ram_burst_buffer.sv - packet buffer built from the burst controller and the 16x8 RAM
module ram_burst_buffer
  import ram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [RAM_DATA_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [RAM_DATA_W-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [RAM_ADDR_W:0]   pkt_len,
  output logic                  truncated
);

  logic [RAM_ADDR_W-1:0] ram_address;
  logic [RAM_DATA_W-1:0] ram_data_in;
  logic [RAM_DATA_W-1:0] ram_data_out;
  logic                  ram_write_en;

  ram_sp_burst_ctrl #(
    .DATA_W (RAM_DATA_W),
    .ADDR_W (RAM_ADDR_W),
    .DEPTH  (RAM_DEPTH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out),
    .pkt_len      (pkt_len),
    .truncated    (truncated)
  );

  ram_sp_16x8 #(
    .DATA_W (RAM_DATA_W),
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk      (clk),
    .address  (ram_address),
    .data_in  (ram_data_in),
    .write_en (ram_write_en),
    .data_out (ram_data_out)
  );

endmodule

// File: rtl/ram_sp_16x8.sv
// rtl/ram_sp_16x8.sv - single-port RAM with synchronous read, no reset on contents
module ram_sp_16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[address] <= data_in;
    end
    data_out <= mem[address];
  end

endmodule

// File: rtl/ram_sp_burst_ctrl.sv
// rtl/ram_sp_burst_ctrl.sv - fills a packet into a single-port RAM, then drains it with backpressure
module ram_sp_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   pkt_len,
  output logic              truncated
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_LEN  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  ctrl_state_e     state, state_nxt;
  logic [ADDR_W:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0] len_q, len_nxt;
  logic            trunc_q, trunc_nxt;
  logic            accept;
  logic            last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      len_q   <= len_nxt;
      trunc_q <= trunc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    len_nxt      = len_q;
    trunc_nxt    = trunc_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    ram_write_en = 1'b0;
    ram_address  = '0;
    accept       = 1'b0;
    last_beat    = 1'b0;

    case (state)
      ST_IDLE: begin
        in_ready     = rst_n;
        accept       = in_valid & rst_n;
        ram_write_en = accept;
        if (accept) begin
          trunc_nxt  = 1'b0;
          wr_ptr_nxt = ONE;
          if (in_last) begin
            len_nxt   = ONE;
            state_nxt = ST_PRIME;
          end else begin
            state_nxt = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        in_ready     = rst_n;
        accept       = in_valid & rst_n;
        ram_write_en = accept;
        ram_address  = wr_ptr[ADDR_W-1:0];
        if (accept) begin
          wr_ptr_nxt = wr_ptr + ONE;
          if (in_last) begin
            len_nxt   = wr_ptr + ONE;
            state_nxt = ST_PRIME;
          end else if (wr_ptr == LAST_ADDR) begin
            len_nxt   = FULL_LEN;
            trunc_nxt = 1'b1;
            state_nxt = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        in_ready = rst_n;
        accept   = in_valid & rst_n;
        if (accept && in_last) begin
          state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        // Address 0 is registered by the RAM here so the first word is ready in DRAIN.
        rd_ptr_nxt = '0;
        state_nxt  = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid   = 1'b1;
        last_beat   = (rd_ptr == len_q - ONE);
        out_last    = last_beat;
        ram_address = rd_ptr[ADDR_W-1:0];
        if (out_ready) begin
          if (last_beat) begin
            state_nxt = ST_IDLE;
          end else begin
            // Look one word ahead so the next beat is ready after the handshake edge.
            rd_ptr_nxt  = rd_ptr + ONE;
            ram_address = rd_ptr_nxt[ADDR_W-1:0];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ram_data_in = in_data;
  // Gate the RAM word so uninitialised contents never reach the output stream.
  assign out_data    = out_valid ? ram_data_out : '0;
  assign pkt_len     = len_q;
  assign truncated   = trunc_q;

endmodule

// File: tb/tb_ram_sp_burst_ctrl.sv
// tb/tb_ram_sp_burst_ctrl.sv - self-checking bench for the burst controller with a behavioural RAM
module tb_ram_sp_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_write_en;
  logic [4:0] pkt_len;
  logic       truncated;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:15];
  logic [7:0] pkt [0:31];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  ram_sp_burst_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out),
    .pkt_len      (pkt_len),
    .truncated    (truncated)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offers pkt[0..n-1] and then measures the edges from the last accept to out_valid.
  task automatic send(input int n, input bit dense);
    int i = 0;
    int guard = 0;
    int cnt = 0;
    while (i < n && guard < 400) begin
      @(negedge clk);
      in_valid = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data  = pkt[i];
      in_last  = (i == n - 1);
      #1;
      if (in_valid && in_ready) i++;
      guard++;
    end
    if (i < n) chk("send_timeout", guard, 0);
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      cnt++;
      if (cnt == 1) chk("prime_in_ready", in_ready, 0);
    end while (!out_valid && cnt < 20);
    chk("latency", cnt, 2);
  endtask

  // Consumes stop beats; the expected stream is the first min(n,16) bytes of the packet.
  task automatic drain(input int n, input bit use_pat, input logic [31:0] pat, input int stop);
    int exp_n = (n > 16) ? 16 : n;
    int idx = 0;
    int k = 0;
    while (idx < stop && k < 400) begin
      chk("out_valid", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      chk("out_data", out_data, pkt[idx]);
      chk("out_last", out_last, (idx == exp_n - 1));
      if (k == 0) begin
        chk("pkt_len", pkt_len, exp_n);
        chk("truncated", truncated, (n > 16));
      end
      out_ready = use_pat ? pat[k % 32] : ($urandom_range(0, 3) != 0);
      k++;
      @(negedge clk);
      #1;
      if (out_ready) idx++;
    end
    if (idx < stop) chk("drain_timeout", k, 0);
    out_ready = 1'b0;
    if (stop == exp_n) begin
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_idle", in_ready, 1);
    end
  endtask

  task automatic run_pkt(input int n, input bit dense, input bit use_pat, input logic [31:0] pat);
    int exp_n = (n > 16) ? 16 : n;
    send(n, dense);
    drain(n, use_pat, pat, exp_n);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_truncated", truncated, 0);
    chk("rst_write_en", ram_write_en, 0);
    chk("rst_address", ram_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    run_pkt(4, 1'b1, 1'b1, 32'hFFFF_FFFF);

    pkt[0] = 8'hA5;
    run_pkt(1, 1'b1, 1'b1, 32'hFFFF_FFFF);

    for (int i = 0; i < 20; i++) pkt[i] = 8'(i);
    run_pkt(16, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_pkt(20, 1'b1, 1'b1, 32'hFFFF_FFFF);

    // out_ready sequence 1,0,0,1,0,1,1 from bit 0 upward
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33; pkt[3] = 8'h44;
    run_pkt(4, 1'b1, 1'b1, 32'h0000_0069);

    send(4, 1'b1);
    drain(4, 1'b1, 32'hFFFF_FFFF, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_pkt_len", pkt_len, 0);
    chk("abort_write_en", ram_write_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    pkt[0] = 8'hC0; pkt[1] = 8'hC1; pkt[2] = 8'hC2;
    run_pkt(3, 1'b1, 1'b1, 32'hFFFF_FFFF);

    for (int p = 0; p < 12; p++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
      run_pkt(n, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
